pll_drp_sequencer: RTL and testbench
====================================

# pll_drp_sequencer

Sequencer that reprograms a PLLE3_ADV through its dynamic reconfiguration port (DRP). It runs on the DRP clock and holds a small table of masked register writes. On `start` it holds the PLL in reset, read-modify-writes each table entry, releases reset, then waits for `locked` with a timeout. It sits between a host/config source and the PLL's `RST`, `DADDR`/`DI`/`DO`/`DEN`/`DWE`/`DRDY` and `LOCKED` pins.

## Interface
Parameters:
- `ENTRIES`, default 8: table depth; power of two, ≥ 2.
- `DRDY_TIMEOUT`, default 64: maximum cycles from `DEN` to `DRDY`.
- `LOCK_TIMEOUT`, default 65535: maximum cycles from reset release to `locked`.

Ports:
- `clk` in 1: DRP clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: write the table entry at `cfg_idx`; ignored while `busy`.
- `cfg_idx` in $clog2(ENTRIES): table index.
- `cfg_daddr` in 7: DRP address for the entry.
- `cfg_mask` in 16: bits set to 1 are preserved from the read value.
- `cfg_data` in 16: new bits; only bits where `cfg_mask`=0 are used.
- `cfg_count` in $clog2(ENTRIES)+1: number of entries to apply; sampled at `start`; 0..ENTRIES.
- `start` in 1: one-cycle request; ignored while `busy`.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on success.
- `error` out 1: sticky; cleared by the next accepted `start`.
- `err_code` out 2: 0 none, 1 DRDY timeout, 2 lock timeout.
- `pll_rst` out 1: to PLL `RST`.
- `daddr` out 7, `di` out 16, `den` out 1, `dwe` out 1: DRP outputs.
- `do_i` in 16, `drdy` in 1, `locked` in 1: DRP read data, DRP ready, PLL lock.

## Operation
- Reset values:
  - `busy`, `done`, `error`, `den`, `dwe`, `pll_rst` = 0.
  - `err_code` = 0; `daddr`, `di` = 0.
  - State IDLE; the table is not reset (contents undefined).
- States and transitions:
  - IDLE: on `start`, latch `cfg_count` into `n`, clear `idx`, `error` and `err_code`, set `busy`. Go to RST.
  - RST: drive `pll_rst`=1. If `n`=0, go to RELEASE; else go to RD.
  - RD: one-cycle `den`=1, `dwe`=0, `daddr`=table[idx].daddr. Go to RD_W.
  - RD_W: on `drdy`, capture `v = (do_i & mask) | (data & ~mask)`. Go to WR.
  - WR: one-cycle `den`=1, `dwe`=1, `di`=v, same `daddr`. Go to WR_W.
  - WR_W: on `drdy`, increment `idx`. If `idx`+1 = `n`, go to RELEASE; else go to RD.
  - RELEASE: drive `pll_rst`=0, clear the timer. Go to LOCK.
  - LOCK: if `locked`=1, pulse `done` and go to IDLE.
  - ERR: drive `pll_rst`=1 (the PLL stays held), `error`=1, `busy`=0. Go to IDLE the next cycle; `pll_rst` stays 1 until the next `start` sequence releases it.
- Timeouts:
  - RD_W or WR_W: one shared timer. It reaches `DRDY_TIMEOUT` with no `drdy`: set `err_code`=1 and go to ERR.
  - LOCK: the timer reaches `LOCK_TIMEOUT`: set `err_code`=2 and go to ERR.
- `pll_rst` is 1 from RST through WR_W, inclusive.
- `drdy` arriving in any state other than RD_W or WR_W is ignored.
- `locked` is used directly. It is a quasi-static PLL output; the block does not synchronize it.
- `cfg_we` while `busy` is dropped, so the table stays stable during a sequence.
- `rst` asserted mid-sequence:
  - Everything returns to reset values immediately, including `pll_rst`=0.
  - Any outstanding DRP transaction is abandoned.

## Timing
- `start` to first `den`: 2 cycles. `start` is sampled at edge 0; RST occupies cycle 1; `den` is high in cycle 2.
- `den` is high for exactly 1 cycle per transaction; `dwe` is high only in the same cycle as a write `den`.
- `daddr` and `di` are held stable from `den` until `drdy`.
- Per entry with immediate `drdy`: 4 cycles (RD, RD_W, WR, WR_W).
- `drdy` to the next `den`: 1 cycle.
- `locked` high to `done`: 1 cycle. `busy` falls in the same cycle `done` pulses.
- The timer is 16 bits wide and saturates.

## Test plan
- Single entry: `daddr`=0x08, `mask`=0xF000, `data`=0x0145; DRP model returns `do`=0xA3C3 after 3 cycles → write `di`=0xA145 to 0x08, `pll_rst` 1→0, `locked` after 100 cycles → `done` pulse, `error`=0.
- Full table: 8 entries, `cfg_count`=8 → exactly 8 read/write pairs at the programmed addresses in index order; exactly 16 `den` pulses; `dwe` only on the writes.
- `cfg_count`=0 → no `den` activity; `pll_rst` high for 1 cycle; `done` follows `locked`.
- DRP model never asserts `drdy` on the 2nd read → `error`=1, `err_code`=1 after 64 cycles, `pll_rst` stays 1; a new `start` clears `error`.
- `locked` never rises, `LOCK_TIMEOUT` overridden to 200 → `err_code`=2 at cycle 200 after release.
- `rst` pulsed during WR_W, plus `start` and `cfg_we` while `busy` → all outputs at reset values, PLL released, the extra `start` ignored, table unchanged.

Source files
------------

// File: rtl/pll_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_drp_sequencer
// Description : Reprograms a PLLE3_ADV over its DRP. Holds the PLL in reset,
//               read-modify-writes a small table of masked register updates,
//               releases reset and waits for lock, with DRDY/lock timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_drp_sequencer #(
    parameter int ENTRIES      = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(ENTRIES)-1:0] cfg_idx,
    input  logic [6:0]                 cfg_daddr,
    input  logic [15:0]                cfg_mask,
    input  logic [15:0]                cfg_data,
    input  logic [$clog2(ENTRIES):0]   cfg_count,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic                       pll_rst,
    output logic [6:0]                 daddr,
    output logic [15:0]                di,
    output logic                       den,
    output logic                       dwe,
    input  logic [15:0]                do_i,
    input  logic                       drdy,
    input  logic                       locked
);

    localparam int c_IW = $clog2(ENTRIES);
    localparam int c_CW = c_IW + 1;

    localparam logic [15:0] c_DRDY_LIMIT = 16'(DRDY_TIMEOUT - 1);
    localparam logic [15:0] c_LOCK_LIMIT = 16'(LOCK_TIMEOUT - 1);

    localparam logic [3:0] c_S_IDLE    = 4'd0;
    localparam logic [3:0] c_S_RST     = 4'd1;
    localparam logic [3:0] c_S_RD      = 4'd2;
    localparam logic [3:0] c_S_RD_W    = 4'd3;
    localparam logic [3:0] c_S_WR      = 4'd4;
    localparam logic [3:0] c_S_WR_W    = 4'd5;
    localparam logic [3:0] c_S_RELEASE = 4'd6;
    localparam logic [3:0] c_S_LOCK    = 4'd7;
    localparam logic [3:0] c_S_ERR     = 4'd8;

    // Register table (not reset; contents are defined only once written)
    logic [6:0]  r_tbl_daddr [ENTRIES];
    logic [15:0] r_tbl_mask  [ENTRIES];
    logic [15:0] r_tbl_data  [ENTRIES];

    logic [3:0]      r_state;
    logic [c_IW-1:0] r_idx;
    logic [c_CW-1:0] r_n;
    logic [15:0]     r_timer;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [1:0]      r_err_code;
    logic            r_pll_rst;
    logic [6:0]      r_daddr;
    logic [15:0]     r_di;
    logic            r_den;
    logic            r_dwe;

    logic [c_CW-1:0] w_idx_next;
    logic            w_last;
    logic [15:0]     w_merged;
    logic [15:0]     w_timer_inc;

    assign w_idx_next  = {1'b0, r_idx} + c_CW'(1);
    assign w_last      = (w_idx_next == r_n);
    // Masked bits come from the PLL, the rest from the table entry
    assign w_merged    = (do_i & r_tbl_mask[r_idx]) | (r_tbl_data[r_idx] & ~r_tbl_mask[r_idx]);
    assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

    // Table writes are accepted only while no sequence is running
    always_ff @(posedge clk) begin
        if (cfg_we && !r_busy) begin
            r_tbl_daddr[cfg_idx] <= cfg_daddr;
            r_tbl_mask[cfg_idx]  <= cfg_mask;
            r_tbl_data[cfg_idx]  <= cfg_data;
        end
    end

    // Sequencer FSM; every output is set on entry to the state that owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_idx      <= '0;
            r_n        <= '0;
            r_timer    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
            r_pll_rst  <= 1'b0;
            r_daddr    <= '0;
            r_di       <= '0;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_n        <= cfg_count;
                        r_idx      <= '0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'd0;
                        r_busy     <= 1'b1;
                        r_pll_rst  <= 1'b1;
                        r_state    <= c_S_RST;
                    end
                end
                c_S_RST: begin
                    if (r_n == '0) begin
                        r_pll_rst <= 1'b0;
                        r_state   <= c_S_RELEASE;
                    end else begin
                        r_den   <= 1'b1;
                        r_dwe   <= 1'b0;
                        r_daddr <= r_tbl_daddr[r_idx];
                        r_state <= c_S_RD;
                    end
                end
                c_S_RD: begin
                    r_den   <= 1'b0;
                    r_timer <= '0;
                    r_state <= c_S_RD_W;
                end
                c_S_RD_W: begin
                    if (drdy) begin
                        r_di    <= w_merged;
                        r_den   <= 1'b1;
                        r_dwe   <= 1'b1;
                        r_state <= c_S_WR;
                    end else if (r_timer == c_DRDY_LIMIT) begin
                        r_err_code <= 2'd1;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_pll_rst  <= 1'b1;
                        r_state    <= c_S_ERR;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                c_S_WR: begin
                    r_den   <= 1'b0;
                    r_dwe   <= 1'b0;
                    r_timer <= '0;
                    r_state <= c_S_WR_W;
                end
                c_S_WR_W: begin
                    if (drdy) begin
                        r_idx <= w_idx_next[c_IW-1:0];
                        if (w_last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= c_S_RELEASE;
                        end else begin
                            r_den   <= 1'b1;
                            r_daddr <= r_tbl_daddr[w_idx_next[c_IW-1:0]];
                            r_state <= c_S_RD;
                        end
                    end else if (r_timer == c_DRDY_LIMIT) begin
                        r_err_code <= 2'd1;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_pll_rst  <= 1'b1;
                        r_state    <= c_S_ERR;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                c_S_RELEASE: begin
                    r_timer <= '0;
                    r_state <= c_S_LOCK;
                end
                c_S_LOCK: begin
                    if (locked) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end else if (r_timer == c_LOCK_LIMIT) begin
                        r_err_code <= 2'd2;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_pll_rst  <= 1'b1;
                        r_state    <= c_S_ERR;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                c_S_ERR: begin
                    // PLL stays held in reset until the next sequence releases it
                    r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;
    assign pll_rst  = r_pll_rst;
    assign daddr    = r_daddr;
    assign di       = r_di;
    assign den      = r_den;
    assign dwe      = r_dwe;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_drp_sequencer
// Description : Self-checking bench for pll_drp_sequencer with a DRP register
//               model, a PLL lock model and table-driven merge vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [6:0]  cfg_daddr;
    logic [15:0] cfg_mask;
    logic [15:0] cfg_data;
    logic [3:0]  cfg_count;
    logic        start;
    logic        busy, done, error, pll_rst, den, dwe;
    logic [1:0]  err_code;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] do_i;
    logic        drdy;
    logic        locked;

    pll_drp_sequencer #(
        .ENTRIES      (8),
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (200)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_daddr (cfg_daddr),
        .cfg_mask  (cfg_mask),
        .cfg_data  (cfg_data),
        .cfg_count (cfg_count),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .pll_rst   (pll_rst),
        .daddr     (daddr),
        .di        (di),
        .den       (den),
        .dwe       (dwe),
        .do_i      (do_i),
        .drdy      (drdy),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // ---------------- DRP register model ----------------
    logic [15:0] mem [128];
    int          lat      = 1;
    int          drop_rd  = 0;
    int          rd_seen  = 0;
    int          den_cnt  = 0;
    int          rst_hi_cnt = 0;
    int          stray_dwe  = 0;
    int          rst_low_at_den = 0;
    int          unstable = 0;
    logic [6:0]  log_addr [$];
    logic        log_we   [$];
    logic [15:0] log_di   [$];
    int          log_cyc  [$];
    bit          pend;
    int          pend_cnt;
    logic        pend_we;
    logic [6:0]  pend_addr;
    logic [15:0] pend_di;

    initial begin
        drdy = 1'b0;
        do_i = '0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            drdy = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pll_rst) rst_hi_cnt++;
                if (dwe && !den) stray_dwe++;
                if (pend) begin
                    if (daddr !== pend_addr || (pend_we && di !== pend_di)) unstable++;
                    if (pend_cnt <= 1) begin
                        drdy = 1'b1;
                        pend = 1'b0;
                        if (pend_we) mem[pend_addr] = pend_di;
                        else         do_i = mem[pend_addr];
                    end else begin
                        pend_cnt--;
                    end
                end
                if (den) begin
                    den_cnt++;
                    log_addr.push_back(daddr);
                    log_we.push_back(dwe);
                    log_di.push_back(di);
                    log_cyc.push_back(cyc);
                    if (!pll_rst) rst_low_at_den++;
                    if (!dwe) rd_seen++;
                    if (dwe || rd_seen != drop_rd) begin
                        pend      = 1'b1;
                        pend_cnt  = lat;
                        pend_we   = dwe;
                        pend_addr = daddr;
                        pend_di   = di;
                    end
                end
            end
        end
    end

    // ---------------- PLL lock model ----------------
    bit lock_en       = 1'b1;
    int lock_delay    = 100;
    int lock_cnt      = 0;
    int lock_rise_cyc = 0;

    initial begin
        locked = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || pll_rst || !lock_en) begin
                locked   = 1'b0;
                lock_cnt = 0;
            end else if (!locked) begin
                if (lock_cnt >= lock_delay) begin
                    locked        = 1'b1;
                    lock_rise_cyc = cyc;
                end else begin
                    lock_cnt++;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    int start_cyc;

    task automatic wr_entry(input int idx, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_daddr = a; cfg_mask = m; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic launch(input logic [3:0] cnt);
        @(negedge clk);
        log_addr.delete(); log_we.delete(); log_di.delete(); log_cyc.delete();
        den_cnt = 0; rd_seen = 0; rst_hi_cnt = 0; stray_dwe = 0;
        rst_low_at_den = 0; unstable = 0;
        start_cyc = cyc;
        cfg_count = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit got_done, output bit got_err, output int when);
        got_done = 1'b0; got_err = 1'b0; when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done)  begin got_done = 1'b1; when = cyc; break; end
            if (error) begin got_err  = 1'b1; when = cyc; break; end
        end
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] rd_val;
        logic [15:0] exp_di;
    } vec_t;

    vec_t vecs [4];

    initial begin
        bit gd, ge;
        int when, rel, busy_at_done, ok;

        vecs[0] = '{7'h08, 16'hF000, 16'h0145, 16'hA3C3, 16'hA145};
        vecs[1] = '{7'h01, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234};
        vecs[2] = '{7'h42, 16'hFFFF, 16'h1234, 16'h5A5A, 16'h5A5A};
        vecs[3] = '{7'h7F, 16'h00FF, 16'hAB00, 16'h12CD, 16'hABCD};

        rst = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_daddr = 0; cfg_mask = 0;
        cfg_data = 0; cfg_count = 0; start = 0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_outputs", {busy, done, error, err_code, pll_rst, den, dwe}, 32'h0);
        chk("rst_daddr_di", {daddr, di}, 32'h0);

        // Single-entry read-modify-write vectors
        lat = 3;
        for (int v = 0; v < 4; v++) begin
            wr_entry(0, vecs[v].addr, vecs[v].mask, vecs[v].data);
            mem[vecs[v].addr] = vecs[v].rd_val;
            launch(4'd1);
            wait_end(400, gd, ge, when);
            busy_at_done = busy;
            chk($sformatf("v%0d_done", v), {gd, ge, error}, {1'b1, 1'b0, 1'b0});
            ok = (log_addr.size() == 2) ? 1 : 0;
            chk($sformatf("v%0d_den_count", v), ok, 1);
            if (ok == 1) begin
                chk($sformatf("v%0d_rd", v), {log_we[0], 9'h0, log_addr[0]}, {1'b0, 9'h0, vecs[v].addr});
                chk($sformatf("v%0d_wr_addr", v), {log_we[1], 9'h0, log_addr[1]}, {1'b1, 9'h0, vecs[v].addr});
                chk($sformatf("v%0d_wr_di", v), log_di[1], vecs[v].exp_di);
            end
            chk($sformatf("v%0d_mem", v), mem[vecs[v].addr], vecs[v].exp_di);
            chk($sformatf("v%0d_pll_rst_released", v), pll_rst, 1'b0);
            if (v == 0) begin
                if (log_cyc.size() > 0) chk("start_to_den", log_cyc[0] - start_cyc, 2);
                chk("locked_to_done", when - lock_rise_cyc, 1);
                chk("busy_low_with_done", busy_at_done, 0);
                chk("pll_rst_during_den", rst_low_at_den, 0);
            end
        end

        // Full table, immediate DRDY
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            wr_entry(i, 7'(8'h10 + i), 16'hFF00, {8'h00, 8'(i * 17)});
            mem[8'h10 + i] = {8'(i + 1), 8'hEE};
        end
        launch(4'd8);
        wait_end(400, gd, ge, when);
        chk("full_done", {gd, ge}, {1'b1, 1'b0});
        chk("full_den_pulses", den_cnt, 16);
        chk("full_stray_dwe", stray_dwe, 0);
        chk("full_addr_stable", unstable, 0);
        chk("full_pll_rst_during_den", rst_low_at_den, 0);
        if (log_addr.size() == 16) begin
            ok = 1;
            for (int k = 0; k < 16; k++)
                if (log_addr[k] != 7'(8'h10 + k / 2) || log_we[k] != 1'((k % 2))) ok = 0;
            chk("full_order", ok, 1);
            for (int i = 0; i < 8; i++)
                chk($sformatf("full_wr_di_%0d", i), log_di[2 * i + 1], {8'(i + 1), 8'(i * 17)});
            chk("full_entry_cycles", log_cyc[2] - log_cyc[0], 4);
            chk("full_drdy_to_den", log_cyc[1] - log_cyc[0], 2);
        end

        // Zero-length sequence
        launch(4'd0);
        wait_end(400, gd, ge, when);
        chk("zero_done", {gd, ge}, {1'b1, 1'b0});
        chk("zero_no_den", den_cnt, 0);
        chk("zero_pll_rst_cycles", rst_hi_cnt, 1);

        // DRDY never returns on the second read
        drop_rd = 2;
        launch(4'd2);
        wait_end(400, gd, ge, when);
        chk("drdy_to_error", {gd, ge, err_code}, {1'b0, 1'b1, 2'd1});
        if (log_cyc.size() >= 3) chk_range("drdy_timeout_cycles", when - log_cyc[2], 60, 70);
        else chk("drdy_second_read_seen", log_cyc.size(), 3);
        repeat (3) @(negedge clk);
        chk("drdy_err_held", {error, busy, pll_rst, den}, {1'b1, 1'b0, 1'b1, 1'b0});
        drop_rd = 0;
        launch(4'd2);
        chk("restart_clears_error", {error, err_code, busy}, {1'b0, 2'd0, 1'b1});
        wait_end(400, gd, ge, when);
        chk("restart_done", {gd, ge}, {1'b1, 1'b0});

        // Lock never arrives
        lock_en = 1'b0;
        launch(4'd0);
        rel = -1;
        for (int i = 0; i < 20; i++) begin
            if (!pll_rst) begin rel = cyc; break; end
            @(negedge clk);
        end
        chk("lock_release_seen", (rel >= 0) ? 1 : 0, 1);
        wait_end(400, gd, ge, when);
        chk("lock_to_error", {gd, ge, err_code, pll_rst}, {1'b0, 1'b1, 2'd2, 1'b1});
        chk_range("lock_timeout_cycles", when - rel, 195, 205);
        lock_en = 1'b1;

        // Reset mid-write, with start and cfg_we while busy
        lat = 10;
        wr_entry(0, 7'h20, 16'h0000, 16'h1111);
        launch(4'd1);
        @(negedge clk);
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_daddr = 7'h55;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        for (int i = 0; i < 50 && log_addr.size() < 2; i++) @(negedge clk);
        chk("rstmid_write_issued", log_addr.size(), 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_outputs", {busy, done, error, err_code, pll_rst, den, dwe}, 32'h0);
        chk("rstmid_daddr_di", {daddr, di}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstmid_quiet", {busy, pll_rst, 6'h0, den_cnt[7:0]}, {1'b0, 1'b0, 6'h0, 8'd2});
        lat = 1;
        launch(4'd1);
        wait_end(400, gd, ge, when);
        chk("rstmid_rerun_done", {gd, ge}, {1'b1, 1'b0});
        if (log_addr.size() > 0) chk("rstmid_table_kept", log_addr[0], 7'h20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
